// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
// Build with BTN_LONG_PRESS_EN defined to enable the long-press detector.
package btn_pkg;

  typedef enum logic [1:0] {
    S_LO,
    S_CHK_HI,
    S_HI,
    S_CHK_LO
  } btn_state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, qualify-then-accept debounce FSM,
// registered edge pulses, press counter and (BTN_LONG_PRESS_EN) long-press pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_in,
  output logic                   btn_level,
  output logic                   btn_rise,
  output logic                   btn_fall,
  output logic [PRESS_CNT_W-1:0] press_count,
  output logic                   long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   s1_q, s1_d, s2_q, s2_d;
  btn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [PRESS_CNT_W-1:0] count_q, count_d;

  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      S_LO: begin
        if (s2_q) begin
          state_d = S_CHK_HI;
          cnt_d   = '0;
        end
      end
      S_CHK_HI: begin
        if (!s2_q) begin
          state_d = S_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (!s2_q) begin
          state_d = S_CHK_LO;
          cnt_d   = '0;
        end
      end
      S_CHK_LO: begin
        if (s2_q) begin
          state_d = S_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign press_count = count_q;

`ifdef BTN_LONG_PRESS_EN
  // Hold counter saturates one past the threshold so the pulse cannot repeat.
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              armed_q, armed_d;
  logic              long_q, long_d;

  always_comb begin
    hold_d  = '0;
    armed_d = armed_q;
    long_d  = 1'b0;
    if (state_q == S_CHK_HI && state_d == S_HI) begin
      armed_d = 1'b1;
    end else if (state_q == S_HI && state_d == S_HI) begin
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
      if (hold_q == HOLD_LAST && armed_q) begin
        long_d  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= '0;
      armed_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      armed_q <= armed_d;
      long_q  <= long_d;
    end
  end

  assign long_press = long_q;
`else
  // Without the hold counter the threshold has no effect on the output.
  assign long_press = 1'b0 & (LONG_CYCLES > 0);
`endif

endmodule

// File: rtl/btn_debounce.sv
// Board-level debouncer: N_BTN independent channels with packed outputs.
// Long-press pulses are produced only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_BTN-1:0]             btn_in,
  output logic [N_BTN-1:0]             btn_level,
  output logic [N_BTN-1:0]             btn_rise,
  output logic [N_BTN-1:0]             btn_fall,
  output logic [PRESS_CNT_W*N_BTN-1:0] press_count,
  output logic [N_BTN-1:0]             long_press
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in[gi]),
      .btn_level  (btn_level[gi]),
      .btn_rise   (btn_rise[gi]),
      .btn_fall   (btn_fall[gi]),
      .press_count(press_count[PRESS_CNT_W*gi +: PRESS_CNT_W]),
      .long_press (long_press[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed + random checks of btn_debounce against a run-length reference model.
// Define BTN_LONG_PRESS_EN for both DUT and bench to check the long-press feature.
module tb_btn_debounce;

  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  btn_in = '0;
  logic [N-1:0]  btn_level, btn_rise, btn_fall, long_press;
  logic [8*N-1:0] press_count;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .press_count(press_count), .long_press(long_press)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: sync is a 2-sample delay; the level flips once D+1
  // consecutive synchronised samples disagree with it.
  bit  m_s1[N], m_s2[N], m_lvl[N], m_armed[N], m_dip[N];
  int  m_run[N], m_hold[N], m_cnt[N];
  logic [N-1:0] e_rise, e_fall, e_long;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit seen;
    e_rise = '0; e_fall = '0; e_long = '0;
    for (int c = 0; c < N; c++) begin
      if (!rst_n) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_armed[c] = 0; m_dip[c] = 0;
        m_run[c] = 0; m_hold[c] = 0; m_cnt[c] = 0;
      end else begin
        seen = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = btn_in[c];
        m_run[c] = (seen != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 1) begin
          m_run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e_rise[c] = 1'b1;
            m_cnt[c] = (m_cnt[c] + 1) % 256;
            m_hold[c] = 0; m_armed[c] = 1; m_dip[c] = 0;
          end else begin
            e_fall[c] = 1'b1;
          end
        end else if (m_lvl[c]) begin
          if (!seen) begin
            m_hold[c] = 0; m_dip[c] = 1;
          end else if (m_dip[c]) begin
            m_hold[c] = 0; m_dip[c] = 0;
          end else begin
            if (m_hold[c] < L) m_hold[c]++;
            if (m_hold[c] == L && m_armed[c]) begin
              e_long[c] = 1'b1; m_armed[c] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] lvl;
    logic [8*N-1:0] cnt;
    for (int c = 0; c < N; c++) begin
      lvl[c] = m_lvl[c];
      cnt[8*c +: 8] = 8'(m_cnt[c]);
    end
    check("level", 32'(btn_level), 32'(lvl));
    check("rise", 32'(btn_rise), 32'(e_rise));
    check("fall", 32'(btn_fall), 32'(e_fall));
    check("press_count", press_count, cnt);
`ifdef BTN_LONG_PRESS_EN
    check("long_press", 32'(long_press), 32'(e_long));
`else
    check("long_press", 32'(long_press), 32'd0);
`endif
  endtask

  task automatic cycle(input logic [N-1:0] b, input logic r);
    btn_in = b;
    rst_n  = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int first;
    int n_rise, n_fall, n_long, t_rise, t_long;
    logic [7:0] cnt_before [N];
    int remain [N];
    logic [N-1:0] cur;

    // Reset with all buttons held, then release: every channel sees a new press.
    for (int i = 0; i < 4; i++) cycle(4'hF, 1'b0);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_count", press_count, 32'd0);
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle(4'hF, 1'b1);
      if (first < 0 && btn_rise == 4'hF) first = i;
    end
    check("reset_rise_edge", 32'(first), 32'd19);
    $display("reset release: rise at edge %0d", first);
    for (int i = 0; i < 30; i++) cycle(4'h0, 1'b1);

    // Clean press on ch0, then hold long enough for a long press.
    first = -1; t_rise = -1; t_long = -1; n_long = 0;
    for (int i = 1; i <= 230; i++) begin
      cycle(4'h1, 1'b1);
      if (btn_rise[0] && t_rise < 0) t_rise = i;
      if (long_press[0]) begin
        n_long++;
        if (t_long < 0) t_long = i;
      end
    end
    check("ch0_rise_edge", 32'(t_rise), 32'd19);
    check("ch0_count", 32'(press_count[7:0]), 32'd2);
`ifdef BTN_LONG_PRESS_EN
    check("ch0_long_count", 32'(n_long), 32'd1);
    check("ch0_long_offset", 32'(t_long - t_rise), 32'(L));
`else
    check("ch0_long_count", 32'(n_long), 32'd0);
`endif
    $display("clean press ch0: rise at %0d, %0d long pulses", t_rise, n_long);
    for (int i = 0; i < 30; i++) cycle(4'h0, 1'b1);

    // Bounce on ch1: toggling every 5 cycles must never be accepted.
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(((i / 5) % 2 == 0) ? 4'h2 : 4'h0, 1'b1);
      n_rise += btn_rise[1]; n_fall += btn_fall[1];
    end
    check("bounce_rises", 32'(n_rise), 32'd0);
    check("bounce_falls", 32'(n_fall), 32'd0);
    check("bounce_level", 32'(btn_level[1]), 32'd0);
    for (int i = 0; i < 40; i++) begin
      cycle(4'h2, 1'b1);
      n_rise += btn_rise[1];
    end
    check("bounce_then_hold_rises", 32'(n_rise), 32'd1);
    $display("bounce ch1: %0d rise after settle", n_rise);
    for (int i = 0; i < 30; i++) cycle(4'h0, 1'b1);

    // Release on ch2.
    for (int i = 0; i < 30; i++) cycle(4'h4, 1'b1);
    first = -1; n_rise = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(4'h0, 1'b1);
      if (btn_fall[2] && first < 0) first = i;
      n_rise += btn_rise[2];
    end
    check("ch2_fall_edge", 32'(first), 32'd19);
    check("ch2_no_rise", 32'(n_rise), 32'd0);
    check("ch2_level", 32'(btn_level[2]), 32'd0);
    $display("release ch2: fall at edge %0d", first);

    // 256 presses on ch3 wrap its counter back to where it started.
    for (int c = 0; c < N; c++) cnt_before[c] = press_count[8*c +: 8];
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 22; i++) cycle(4'h8, 1'b1);
      for (int i = 0; i < 22; i++) cycle(4'h0, 1'b1);
    end
    for (int c = 0; c < N; c++)
      check("wrap_count", 32'(press_count[8*c +: 8]), 32'(cnt_before[c]));
    $display("wrap ch3: count %0d after 256 presses", press_count[31:24]);

    // Random per-channel hold lengths, mixing bounces and accepted changes.
    cur = '0;
    for (int c = 0; c < N; c++) remain[c] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++) begin
        remain[c]--;
        if (remain[c] == 0) begin
          cur[c] = ~cur[c];
          remain[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D) : $urandom_range(D, 120);
        end
      end
      cycle(cur, ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1);
    end
    $display("random phase: levels %b counts %h", btn_level, press_count);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
